// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC pipeline sequencer.
// The perf counters in this slice exist only when MAC_SEQ_CTRL_PERF_EN is defined.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  localparam int MAC_PIPE_DEPTH = 5;
  localparam int MAC_LEN_W      = 10;

  // Counters park at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand and result signals of the MAC sequencer, plus its debug view.
// Used the same way whether or not MAC_SEQ_CTRL_PERF_EN is defined.
interface mac_seq_ctrl_if
  import mac_pkg::*;
#(
  parameter int LEN_W      = MAC_LEN_W,
  parameter int PIPE_DEPTH = MAC_PIPE_DEPTH
);
  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_op_valid;
  logic             o_op_ready;
  logic             o_issue;
  logic             o_inhibit;
  logic             i_pipe_valid;
  logic             i_out_ready;
  logic             o_out_last;
  logic             o_busy;
  logic             o_done;

  mac_state_e       dbg_state;
  logic [CNT_W-1:0] dbg_inflight;
  logic             dbg_err;

  // Handshakes: an operand pair moves when i_op_valid & o_op_ready, a result
  // moves when i_pipe_valid & i_out_ready; a valid stays up until taken.
  modport master (
    output i_start, i_len, i_op_valid, i_pipe_valid, i_out_ready,
    input  o_op_ready, o_issue, o_inhibit, o_out_last, o_busy, o_done,
    input  dbg_state, dbg_inflight, dbg_err
  );

  modport slave (
    input  i_start, i_len, i_op_valid, i_pipe_valid, i_out_ready,
    output o_op_ready, o_issue, o_inhibit, o_out_last, o_busy, o_done,
    output dbg_state, dbg_inflight, dbg_err
  );

endinterface

// File: rtl/mac_seq_perf.sv
// Stall and job-length counters for the MAC sequencer.
// Instantiated only when MAC_SEQ_CTRL_PERF_EN is defined.
module mac_seq_perf
  import mac_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_acc,
  input  logic        i_busy,
  input  logic        i_inhibit,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_job_cycles
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] job_q, job_d;

  always_comb begin
    stall_d = stall_q;
    job_d   = job_q;
    if (i_start_acc) begin
      stall_d = '0;
      job_d   = '0;
    end else if (i_busy) begin
      job_d = sat_inc32(job_q);
      if (i_inhibit) stall_d = sat_inc32(stall_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      job_q   <= '0;
    end else begin
      stall_q <= stall_d;
      job_q   <= job_d;
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_job_cycles   = job_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a PIPE_DEPTH-stage MAC pipeline: issues len operand pairs, drains results.
// MAC_SEQ_CTRL_PERF_EN adds o_stall_cycles, o_job_cycles and o_err.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int PIPE_DEPTH = MAC_PIPE_DEPTH,
  parameter int LEN_W      = MAC_LEN_W
)(
  input  logic i_clk,
  input  logic i_rst_n,
  mac_seq_ctrl_if.slave bus
`ifdef MAC_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_job_cycles,
  output logic        o_err
`endif
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic inhibit, op_ready, issue, retire, busy, start_acc;

  // Inhibit is purely combinational so it keeps working while in reset.
  always_comb begin
    inhibit   = bus.i_pipe_valid & ~bus.i_out_ready;
    op_ready  = (state_q == ST_RUN) & ~inhibit;
    issue     = bus.i_op_valid & op_ready;
    retire    = bus.i_pipe_valid & bus.i_out_ready;
    busy      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    start_acc = (state_q == ST_IDLE) & bus.i_start;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    retired_d   = retired_q;
    inflight_d  = inflight_q;
    err_d       = err_q;

    if (issue && !retire) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!issue && retire && inflight_q != '0) begin
      inflight_d = inflight_q - CNT_ONE;
    end

    if (retire && busy) retired_d = retired_q + LEN_ONE;
    if ((state_q == ST_IDLE) && bus.i_pipe_valid) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          len_d       = bus.i_len;
          issue_cnt_d = '0;
          retired_d   = '0;
          state_d     = (bus.i_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + LEN_ONE;
          if (issue_cnt_q == len_q - LEN_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      retired_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      retired_q   <= retired_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_inhibit    = inhibit;
  assign bus.o_op_ready   = op_ready;
  assign bus.o_issue      = issue;
  assign bus.o_busy       = busy;
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_out_last   = bus.i_pipe_valid & busy & (retired_q == len_q - LEN_ONE);
  assign bus.dbg_state    = state_q;
  assign bus.dbg_inflight = inflight_q;
  assign bus.dbg_err      = err_q;

`ifdef MAC_SEQ_CTRL_PERF_EN
  mac_seq_perf u_perf (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start_acc    (start_acc),
    .i_busy         (busy),
    .i_inhibit      (inhibit),
    .o_stall_cycles (o_stall_cycles),
    .o_job_cycles   (o_job_cycles)
  );
  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a 5-stage stallable pipeline model around it.
// Perf-counter checks are compiled in when MAC_SEQ_CTRL_PERF_EN is defined.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int PD = 5;
  localparam int LW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.LEN_W(LW), .PIPE_DEPTH(PD)) bus ();

`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cycles, job_cycles;
  logic        perf_err;
`endif

  mac_seq_ctrl #(.PIPE_DEPTH(PD), .LEN_W(LW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
`ifdef MAC_SEQ_CTRL_PERF_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_job_cycles   (job_cycles),
    .o_err          (perf_err)
`endif
  );

  // Pipeline model: every stage shifts unless globally inhibited.
  logic [PD-1:0] pipe_q;
  logic          inj_valid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else if (!bus.o_inhibit) pipe_q <= {pipe_q[PD-2:0], bus.o_issue};
  end
  assign bus.i_pipe_valid = pipe_q[PD-1] | inj_valid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {op_ready, issue, inhibit, out_last, busy, done}
  function automatic logic [5:0] outs();
    return {bus.o_op_ready, bus.o_issue, bus.o_inhibit, bus.o_out_last, bus.o_busy, bus.o_done};
  endfunction

  typedef struct {
    logic          start;
    logic [LW-1:0] len;
    logic          opv;
    logic          ordy;
    logic [5:0]    exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input logic s, input int len, input logic opv,
                     input logic ordy, input logic [5:0] exp);
    vec_t v;
    v.start = s;
    v.len   = len[LW-1:0];
    v.opv   = opv;
    v.ordy  = ordy;
    v.exp   = exp;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic wait_done(output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      #1;
      if (bus.o_done) begin
        cycles = k;
        seen   = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    int  n_iss;
    int  stall_left;

    bus.i_start     = 1'b0;
    bus.i_len       = '0;
    bus.i_op_valid  = 1'b0;
    bus.i_out_ready = 1'b1;
    inj_valid       = 1'b0;

    // len=4, free-flowing: issues on steps 1-4, last on step 9, done on step 11
    add(1, 1, 4, 1, 1, 6'b000000);
    add(4, 0, 0, 1, 1, 6'b110010);
    add(4, 0, 0, 1, 1, 6'b000010);
    add(1, 0, 0, 1, 1, 6'b000110);
    add(1, 0, 0, 1, 1, 6'b000010);
    add(1, 0, 0, 1, 1, 6'b000001);
    add(1, 0, 0, 1, 1, 6'b000000);
    // len=3 with a 3-cycle output stall that holds back the second issue
    add(1, 1, 3, 0, 1, 6'b000000);
    add(1, 0, 0, 1, 1, 6'b110010);
    add(4, 0, 0, 0, 1, 6'b100010);
    add(3, 0, 0, 1, 0, 6'b001010);
    add(2, 0, 0, 1, 1, 6'b110010);
    add(4, 0, 0, 0, 1, 6'b000010);
    add(1, 0, 0, 0, 1, 6'b000110);
    add(1, 0, 0, 0, 1, 6'b000010);
    add(1, 0, 0, 0, 1, 6'b000001);
    add(1, 0, 0, 0, 1, 6'b000000);
    // len=0 goes straight to DONE
    add(1, 1, 0, 1, 1, 6'b000000);
    add(1, 0, 0, 1, 1, 6'b000001);
    add(1, 0, 0, 1, 1, 6'b000000);

    #1 rst_n = 1'b0;
    #1;
    check("rst_outs", {26'd0, outs()}, 32'h0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    check("rst_inflight", bus.dbg_inflight, 0);
`ifdef MAC_SEQ_CTRL_PERF_EN
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_job_cycles", job_cycles, 0);
    check("rst_err", perf_err, 0);
`endif
    inj_valid       = 1'b1;
    bus.i_out_ready = 1'b0;
    #1;
    check("rst_inhibit_follows", {26'd0, outs()}, {26'd0, 6'b001000});
    inj_valid       = 1'b0;
    bus.i_out_ready = 1'b1;
    #1;
    check("rst_err_masked", bus.dbg_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.i_start     = vecs[i].start;
      bus.i_len       = vecs[i].len;
      bus.i_op_valid  = vecs[i].opv;
      bus.i_out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_outs", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
      check($sformatf("vec%0d_inflight", i), bus.dbg_inflight, $countones(pipe_q));
      check($sformatf("vec%0d_inflight_max", i), bus.dbg_inflight <= PD, 1);
    end
    bus.i_start     = 1'b0;
    bus.i_op_valid  = 1'b0;
    bus.i_out_ready = 1'b1;

    // i_start during RUN must not reload the length
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = 2;
    @(negedge clk);
    bus.i_len = 7;
    #1;
    check("d_run", bus.dbg_state, ST_RUN);
    @(negedge clk);
    bus.i_start    = 1'b0;
    bus.i_op_valid = 1'b1;
    #1;
    n_iss = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.o_issue) n_iss++;
      if (bus.dbg_state != ST_RUN) break;
      @(negedge clk);
      #1;
    end
    check("d_issues", n_iss, 2);
    check("d_drain", bus.dbg_state, ST_DRAIN);
    bus.i_op_valid = 1'b0;
    wait_done(cyc, seen);
    check("d_done_seen", seen, 1);

    // reset with two results in flight, then a clean len=1 job
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_len      = 4;
    bus.i_op_valid = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    #1;
    check("e_inflight_pre", bus.dbg_inflight, 2);
    rst_n = 1'b0;
    #1;
    check("e_rst_outs", {26'd0, outs()}, 32'h0);
    check("e_rst_state", bus.dbg_state, ST_IDLE);
    check("e_rst_inflight", bus.dbg_inflight, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("e_no_done%0d", k), bus.o_done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_len      = 1;
    bus.i_op_valid = 1'b1;
    wait_done(cyc, seen);
    check("e_done_seen", seen, 1);
    check("e_latency", cyc, 1 + PD + 2);
    bus.i_op_valid = 1'b0;

`ifdef MAC_SEQ_CTRL_PERF_EN
    // len=2 with exactly two stalled output cycles
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_len       = 2;
    bus.i_op_valid  = 1'b1;
    bus.i_out_ready = 1'b1;
    stall_left = 2;
    seen       = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.i_pipe_valid && stall_left > 0) begin
        bus.i_out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.i_out_ready = 1'b1;
      end
      #1;
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("f_done_seen", seen, 1);
    check("f_stall_cycles", stall_cycles, 2);
    check("f_job_cycles", job_cycles, 2 + PD + 1 + 2);
    check("f_err_clear", perf_err, 0);
    bus.i_op_valid  = 1'b0;
    bus.i_out_ready = 1'b1;
`else
    stall_left = 0;
`endif

    // stray result while idle raises the sticky protocol error
    @(negedge clk);
    #1;
    check("err_clear", bus.dbg_err, 0);
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    #1;
    check("err_set", bus.dbg_err, 1);
    @(negedge clk);
    #1;
    check("err_sticky", bus.dbg_err, 1);
`ifdef MAC_SEQ_CTRL_PERF_EN
    check("err_port", perf_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL have parameter PIPE_DEPTH, default 5, giving the number of MAC pipeline stages it sequences.
REQ-002 The block SHALL have parameter LEN_W, default 10, giving the width of the accumulation length.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
REQ-004 The block SHALL have these remaining ports:
- i_start  in  1  start-pulse for one accumulation job
- i_len  in  LEN_W  number of operand pairs in the job, sampled on accepted i_start
- i_op_valid  in  1  upstream operand pair available
- o_op_ready  out  1  operand pair accepted this cycle
- o_issue  out  1  drives stage-1 i_valid
- o_inhibit  out  1  global stall to every pipeline stage's i_inhibit
- i_pipe_valid  in  1  final-stage o_valid
- i_out_ready  in  1  downstream consumer ready
- o_out_last  out  1  current output is the job's last result
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle job-complete pulse

Function
REQ-005 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, held in a registered state.
REQ-006 In IDLE, i_start with i_len>0 SHALL latch i_len, clear the issue count and move to RUN next cycle; i_start with i_len==0 SHALL move directly to DONE.
REQ-007 i_start outside IDLE SHALL be ignored.
REQ-008 o_inhibit SHALL equal i_pipe_valid & ~i_out_ready (combinational).
REQ-009 o_op_ready SHALL equal (state==RUN) & ~o_inhibit.
REQ-010 An issue SHALL occur when i_op_valid & o_op_ready, and o_issue SHALL equal that condition.
REQ-011 The issue count SHALL increment on each issue; an issue with count==len-1 SHALL move the FSM to DRAIN.
REQ-012 The in-flight counter, of width clog2(PIPE_DEPTH+1), SHALL increment on issue and decrement on output handshake (i_pipe_valid & i_out_ready); simultaneous increment and decrement SHALL leave it unchanged.
REQ-013 The in-flight counter SHALL NOT exceed PIPE_DEPTH, because issue is gated by inhibit.
REQ-014 The retired count SHALL increment on each output handshake; o_out_last SHALL be asserted while i_pipe_valid and retired==len-1.
REQ-015 DRAIN SHALL move to DONE in the cycle after in-flight reaches 0.
REQ-016 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-017 o_busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-018 A job SHALL take a minimum of len + PIPE_DEPTH + 2 cycles from i_start to o_done when there are no stalls.
REQ-019 o_inhibit SHALL be honoured in every state.
REQ-020 i_pipe_valid received in IDLE SHALL be flagged as an internal protocol error, held sticky until reset.

Reset
REQ-021 Asserting i_rst_n low SHALL immediately force the FSM to IDLE and clear all counters and the latched length.
REQ-022 While in reset, all outputs SHALL be 0: o_op_ready, o_issue, o_out_last, o_busy, o_done and the error flag. o_inhibit SHALL follow i_pipe_valid & ~i_out_ready.
REQ-023 Reset asserted mid-job SHALL abandon the job without asserting o_done; the pipeline is cleared by the same reset.

Configuration
REQ-024 With macro MAC_SEQ_CTRL_PERF_EN defined, the block SHALL add outputs o_stall_cycles[31:0], o_job_cycles[31:0] and o_err.
- o_stall_cycles SHALL count cycles with o_inhibit high while busy.
- o_job_cycles SHALL count busy cycles of the last job.
- Both counters SHALL saturate at max, clear on accepted i_start and reset to 0.
REQ-025 Without MAC_SEQ_CTRL_PERF_EN, those ports and that logic SHALL be absent, and the functional behaviour SHALL be identical.

Structure
REQ-026 The FSM state encoding and the PIPE_DEPTH default constant SHALL reside in shared package mac_pkg.
REQ-027 The perf counters SHALL be a sub-module mac_seq_perf, instantiated only under MAC_SEQ_CTRL_PERF_EN.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- len=4, i_op_valid and i_out_ready held 1 -> 4 issue pulses on consecutive cycles; o_out_last on the 4th output; o_done 11 cycles after i_start.
- len=3, i_out_ready low for 3 cycles while i_pipe_valid=1 -> o_inhibit=1 and o_op_ready=0 for those 3 cycles; no issue is lost; in-flight never exceeds 5.
- len=0 -> o_done one cycle after the DONE transition; no o_issue; o_busy stays 0.
- i_start pulsed during RUN -> ignored; latched len unchanged.
- Reset asserted with 2 results in flight -> all outputs 0 immediately; no o_done; next job runs normally.
- PERF_EN build, len=2 with 2 stall cycles -> o_stall_cycles=2.
